gddr_sync_mc: RTL and testbench

//  Multi-channel, parametrised ECLKSYNC/CLKDIV synchroniser for GDDR banks. Drives stop and
//  ddr_reset to NUM_CH channels: stop on, reset pulse, stop held, stop off, settle, then ready.

---
 rtl/gddr_sync_pkg.sv | 27 ++
 rtl/gddr_sync_timer.sv | 27 ++
 rtl/gddr_sync_mc.sv | 169 ++++++++++++++++
 tb/tb_gddr_sync_mc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gddr_sync_pkg.sv
// rtl/gddr_sync_pkg.sv - shared state encoding, mode constants and counter sizing for gddr_sync_mc
package gddr_sync_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEB    = 3'd1,
        S_STOP1  = 3'd2,
        S_RST    = 3'd3,
        S_STOP2  = 3'd4,
        S_SETTLE = 3'd5,
        S_READY  = 3'd6
    } sync_state_t;

    localparam int SYNC_PAR = 0;
    localparam int SYNC_SEQ = 1;

    // Timed states load (N-1), so clog2 of the largest N is enough.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/gddr_sync_timer.sv
// rtl/gddr_sync_timer.sv - loadable down-counter shared by every timed state of gddr_sync_mc
module gddr_sync_timer #(
    parameter int W = 2
) (
    input  logic         sync_clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge sync_clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/gddr_sync_mc.sv
// rtl/gddr_sync_mc.sv - multi-channel ECLKSYNC/CLKDIV sync sequencer; GDDR_SYNC_LOCK_WAIT_EN adds pll_lock gating
module gddr_sync_mc
    import gddr_sync_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SEQ_MODE  = 0,
    parameter int START_DLY = 4,
    parameter int STOP_CYC  = 4,
    parameter int RST_CYC   = 4,
    parameter int READY_DLY = 8
) (
    input  logic              sync_clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_en,
`ifdef GDDR_SYNC_LOCK_WAIT_EN
    input  logic              pll_lock,
`endif
    output logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] ddr_reset,
    output logic              busy,
    output logic              ready
);

    localparam int CW = cnt_width(START_DLY, STOP_CYC, RST_CYC, READY_DLY);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    sync_state_t       state, state_n;
    logic [NUM_CH-1:0] ch_mask, mask_n;
    logic [IW-1:0]     ch_idx, idx_n;
    logic              hold, hold_n;
    logic              lock_s, go, tmr_done;
    logic [CW-1:0]     load_val;
    logic [IW-1:0]     first_idx, next_idx;
    logic              next_found;
    logic [NUM_CH-1:0] act, stop_n, ddr_n;
    logic              busy_n, ready_n;

`ifdef GDDR_SYNC_LOCK_WAIT_EN
    logic [1:0] lock_sync;

    always_ff @(posedge sync_clk or negedge rstn) begin
        if (!rstn) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], pll_lock};
        end
    end

    assign lock_s = lock_sync[1];
`else
    assign lock_s = 1'b1;
`endif

    assign go = start & lock_s;

    // Lowest set bit of ch_en, and lowest set bit of ch_mask above ch_idx.
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) first_idx = IW'(i);
            if (ch_mask[i] && (IW'(i) > ch_idx)) begin
                next_idx   = IW'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        mask_n  = ch_mask;
        idx_n   = ch_idx;
        hold_n  = hold;
        unique case (state)
            S_IDLE:   if (go && !hold) state_n = S_DEB;
            S_DEB: begin
                if (!go) begin
                    state_n = S_IDLE;
                end else if (tmr_done) begin
                    if (ch_en == '0) begin
                        state_n = S_IDLE;
                        hold_n  = 1'b1;
                    end else begin
                        state_n = S_STOP1;
                        mask_n  = ch_en;
                        idx_n   = first_idx;
                    end
                end
            end
            S_STOP1:  if (!go) state_n = S_IDLE; else if (tmr_done) state_n = S_RST;
            S_RST:    if (!go) state_n = S_IDLE; else if (tmr_done) state_n = S_STOP2;
            S_STOP2: begin
                if (!go) begin
                    state_n = S_IDLE;
                end else if (tmr_done) begin
                    if ((SEQ_MODE == SYNC_SEQ) && next_found) begin
                        state_n = S_STOP1;
                        idx_n   = next_idx;
                    end else begin
                        state_n = S_SETTLE;
                    end
                end
            end
            S_SETTLE: if (!go) state_n = S_IDLE; else if (tmr_done) state_n = S_READY;
            S_READY:  if (!go) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (state_n == S_IDLE) begin
            mask_n = '0;
            idx_n  = '0;
        end
        // An empty capture parks in IDLE until start is released.
        if (!start) hold_n = 1'b0;
    end

    always_comb begin
        load_val = '0;
        case (state_n)
            S_DEB:            load_val = CW'(START_DLY - 1);
            S_STOP1, S_STOP2: load_val = CW'(STOP_CYC - 1);
            S_RST:            load_val = CW'(RST_CYC - 1);
            S_SETTLE:         load_val = CW'(READY_DLY - 1);
            default:          load_val = '0;
        endcase
    end

    gddr_sync_timer #(.W(CW)) u_timer (
        .sync_clk (sync_clk),
        .rstn     (rstn),
        .load     (state_n != state),
        .load_val (load_val),
        .en       (1'b1),
        .done     (tmr_done)
    );

    // Outputs are derived from the next state so they change on the same edge as the state.
    always_comb begin
        act     = (SEQ_MODE == SYNC_SEQ) ? (NUM_CH'(1) << idx_n) : mask_n;
        stop_n  = (state_n inside {S_STOP1, S_RST, S_STOP2}) ? act : '0;
        ddr_n   = (state_n == S_RST) ? act : '0;
        busy_n  = state_n inside {S_DEB, S_STOP1, S_RST, S_STOP2, S_SETTLE};
        ready_n = (state_n == S_READY);
    end

    always_ff @(posedge sync_clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            ch_mask   <= '0;
            ch_idx    <= '0;
            hold      <= 1'b0;
            stop      <= '0;
            ddr_reset <= '1;
            busy      <= 1'b0;
            ready     <= 1'b0;
        end else begin
            state     <= state_n;
            ch_mask   <= mask_n;
            ch_idx    <= idx_n;
            hold      <= hold_n;
            stop      <= stop_n;
            ddr_reset <= ddr_n;
            busy      <= busy_n;
            ready     <= ready_n;
        end
    end

endmodule

// File: tb/tb_gddr_sync_mc.sv
// tb/tb_gddr_sync_mc.sv - scoreboard bench for gddr_sync_mc, parallel and sequential instances
module tb_gddr_sync_mc;

    localparam int D = 4;
    localparam int S = 4;
    localparam int R = 4;
    localparam int Y = 8;
    localparam int W = 2 * S + R;
    localparam logic [9:0] RSTV = {4'h0, 4'hF, 1'b0, 1'b0};

    logic       sync_clk;
    logic       rstn;
    logic       start;
    logic [3:0] ch_en;
`ifdef GDDR_SYNC_LOCK_WAIT_EN
    logic       pll_lock;
    logic [1:0] lq;
`endif
    logic [3:0] stop_p, ddr_p, stop_s, ddr_s;
    logic       busy_p, ready_p, busy_s, ready_s;

    logic [19:0] exp_q[$];
    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          t0;
    logic [3:0]  cmask;
    bit          hold;
    bit          running;

    gddr_sync_mc #(.NUM_CH(4), .SEQ_MODE(0)) dut_par (
        .sync_clk  (sync_clk),
        .rstn      (rstn),
        .start     (start),
        .ch_en     (ch_en),
`ifdef GDDR_SYNC_LOCK_WAIT_EN
        .pll_lock  (pll_lock),
`endif
        .stop      (stop_p),
        .ddr_reset (ddr_p),
        .busy      (busy_p),
        .ready     (ready_p)
    );

    gddr_sync_mc #(.NUM_CH(4), .SEQ_MODE(1)) dut_seq (
        .sync_clk  (sync_clk),
        .rstn      (rstn),
        .start     (start),
        .ch_en     (ch_en),
`ifdef GDDR_SYNC_LOCK_WAIT_EN
        .pll_lock  (pll_lock),
`endif
        .stop      (stop_s),
        .ddr_reset (ddr_s),
        .busy      (busy_s),
        .ready     (ready_s)
    );

    initial sync_clk = 1'b0;
    always #5 sync_clk = ~sync_clk;

    // Waveform at k edges after T0 with start held: debounce, one stop window per group, settle, ready.
    function automatic logic [9:0] exp_out(input int k, input logic [3:0] mask, input bit seq);
        logic [3:0] grp;
        logic [3:0] stp;
        logic [3:0] rst;
        logic       bz;
        logic       rd;
        int         n_grp, j, g, r, cnt;
        grp = '0; stp = '0; rst = '0; bz = 1'b0; rd = 1'b0;
        n_grp = seq ? $countones(mask) : 1;
        if (k < D) begin
            bz = 1'b1;
        end else begin
            j = k - D;
            if (j < n_grp * W) begin
                g = j / W;
                r = j % W;
                if (!seq) begin
                    grp = mask;
                end else begin
                    cnt = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (mask[i]) begin
                            if (cnt == g) grp[i] = 1'b1;
                            cnt++;
                        end
                    end
                end
                stp = grp;
                if (r >= S && r < S + R) rst = grp;
                bz = 1'b1;
            end else if (j < n_grp * W + Y) begin
                bz = 1'b1;
            end else begin
                rd = 1'b1;
            end
        end
        return {stp, rst, bz, rd};
    endfunction

    task automatic step(input logic st, input logic [3:0] en, input logic rn);
        logic [9:0] ep, es;
        logic       go;
        int         k;
        @(posedge sync_clk);
        cyc++;
        ep = '0;
        es = '0;
        if (!rstn) begin
            t0 = -1;
            hold = 1'b0;
`ifdef GDDR_SYNC_LOCK_WAIT_EN
            lq = 2'b00;
`endif
            ep = RSTV;
            es = RSTV;
        end else begin
`ifdef GDDR_SYNC_LOCK_WAIT_EN
            go = start & lq[1];
            lq = {lq[0], pll_lock};
`else
            go = start;
`endif
            if (!start) hold = 1'b0;
            if (!go) begin
                t0 = -1;
            end else begin
                if (t0 < 0 && !hold) t0 = cyc;
                if (t0 >= 0) begin
                    k = cyc - t0;
                    if (k == D) begin
                        cmask = ch_en;
                        if (cmask == 4'h0) begin
                            hold = 1'b1;
                            t0 = -1;
                        end
                    end
                    if (t0 >= 0) begin
                        ep = exp_out(k, cmask, 1'b0);
                        es = exp_out(k, cmask, 1'b1);
                    end
                end
            end
        end
        #1;
        start = st;
        ch_en = en;
        rstn  = rn;
`ifdef GDDR_SYNC_LOCK_WAIT_EN
        pll_lock = ($urandom_range(0, 59) != 0);
`endif
        if (!rn) begin
            ep = RSTV;
            es = RSTV;
        end
        exp_q.push_back({ep, es});
        running = 1'b1;
    endtask

    // Holds start for len cycles, optional reset pulse and start glitch, then releases start.
    task automatic run_seq(input logic [3:0] en, input int len, input int rst_at, input int glitch,
                           input bit scramble);
        logic       st, rn;
        logic [3:0] e;
        for (int c = 0; c < len; c++) begin
            st = 1'b1;
            rn = 1'b1;
            e  = (scramble && c > D + 2) ? 4'($urandom) : en;
            if (c == glitch) st = 1'b0;
            if (rst_at >= 0 && c >= rst_at && c < rst_at + 3) rn = 1'b0;
            step(st, e, rn);
        end
        step(1'b0, en, 1'b1);
        step(1'b0, en, 1'b1);
    endtask

    always @(negedge sync_clk) begin
        logic [19:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({stop_p, ddr_p, busy_p, ready_p} !== e[19:10]) begin
                n_bad++;
                $display("FAIL par cyc=%0d got stop=%h ddr=%h busy=%b ready=%b want stop=%h ddr=%h busy=%b ready=%b",
                         cyc, stop_p, ddr_p, busy_p, ready_p, e[19:16], e[15:12], e[11], e[10]);
            end
            n_cmp++;
            if ({stop_s, ddr_s, busy_s, ready_s} !== e[9:0]) begin
                n_bad++;
                $display("FAIL seq cyc=%0d got stop=%h ddr=%h busy=%b ready=%b want stop=%h ddr=%h busy=%b ready=%b",
                         cyc, stop_s, ddr_s, busy_s, ready_s, e[9:6], e[5:2], e[1], e[0]);
            end
        end else if (running) begin
            n_cmp++;
            n_bad++;
            $display("FAIL no_expectation cyc=%0d got queue=0 want queue>0", cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout got cyc=%0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int len, rst_at, glitch;
        logic [3:0] en;
        n_cmp = 0; n_bad = 0; cyc = 0; t0 = -1; cmask = '0; hold = 1'b0; running = 1'b0;
        rstn = 1'b0; start = 1'b0; ch_en = 4'h0;
`ifdef GDDR_SYNC_LOCK_WAIT_EN
        pll_lock = 1'b1;
        lq = 2'b00;
`endif
        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'hF, 1'b1);
        step(1'b0, 4'hF, 1'b1);

        run_seq(4'hF,    40, -1, -1, 1'b0);
        run_seq(4'b1011, 60, -1, -1, 1'b0);
        run_seq(4'hF,    10, -1, -1, 1'b0);
        run_seq(4'hF,    40, -1, -1, 1'b0);
        run_seq(4'hF,     2, -1, -1, 1'b0);
        repeat (6) step(1'b0, 4'hF, 1'b1);
        run_seq(4'h0,    16, -1, -1, 1'b0);
        run_seq(4'hF,    45, 13, -1, 1'b0);
        run_seq(4'h6,    30, -1,  2, 1'b1);

        for (int s = 0; s < 40; s++) begin
            en = 4'($urandom);
            if ($urandom_range(0, 5) == 0) en = 4'h0;
            len    = $urandom_range(2, 75);
            rst_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 60)) : -1;
            glitch = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_seq(en, len, rst_at, glitch, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) step(1'b0, en, 1'b1);
        end

        @(negedge sync_clk);
        #1;
        running = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain got %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
